// File: rtl/outcome_pkg.sv
// Shared codes for the sequential K-in-a-row outcome scanner: outcomes, cells, directions, FSM states.
package outcome_pkg;

    localparam logic [1:0] IN_PROGRESS = 2'd0;
    localparam logic [1:0] P1_WIN      = 2'd1;
    localparam logic [1:0] P1_LOSE     = 2'd2;
    localparam logic [1:0] TIE         = 2'd3;

    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] P1    = 2'b01;
    localparam logic [1:0] P2    = 2'b10;

    localparam logic [1:0] DIR_RIGHT = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_DIAG  = 2'd2;
    localparam logic [1:0] DIR_ANTI  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Code 11 is deliberately not a player: it counts as empty everywhere.
    function automatic logic is_player(input logic [1:0] v);
        return (v == P1) || (v == P2);
    endfunction

endpackage

// File: rtl/outcome_scanner_if.sv
// Start/done handshake bundle for outcome_scanner.
// win_idx/win_dir exist only when OUTCOME_WIN_LINE_EN is defined.
interface outcome_scanner_if #(
    parameter int N = 3
);
    logic             start;
    logic [2*N*N-1:0] board;
    logic             busy;
    logic             done;
    logic [1:0]       outcome;
`ifdef OUTCOME_WIN_LINE_EN
    localparam int IW = $clog2(N*N);
    logic [IW-1:0]    win_idx;
    logic [1:0]       win_dir;

    modport master (output start, board, input busy, done, outcome, win_idx, win_dir);
    modport slave  (input start, board, output busy, done, outcome, win_idx, win_dir);
`else
    modport master (output start, board, input busy, done, outcome);
    modport slave  (input start, board, output busy, done, outcome);
`endif
endinterface

// File: rtl/outcome_line_check.sv
// Combinational test for a K-cell run of one player starting at an anchor cell in one direction.
module outcome_line_check
    import outcome_pkg::*;
#(
    parameter int N  = 3,
    parameter int K  = 3,
    parameter int RW = $clog2(N)
) (
    input  logic [2*N*N-1:0] i_snap,
    input  logic [RW-1:0]    i_row,
    input  logic [RW-1:0]    i_col,
    input  logic [1:0]       i_dir,
    output logic             o_hit,
    output logic [1:0]       o_player
);

    // Constant-index mux keeps the cell lookup free of variable part-selects.
    function automatic logic [1:0] cell_at(input logic [2*N*N-1:0] s, input int r, input int c);
        logic [1:0] v;
        v = EMPTY;
        for (int i = 0; i < N*N; i++)
            if (i == r*N + c) v = s[2*i +: 2];
        return v;
    endfunction

    int         w_dr;
    int         w_dc;
    int         w_r;
    int         w_c;
    logic [1:0] w_anchor;
    logic       w_eligible;
    logic       w_match;

    always_comb begin
        w_dr = (i_dir == DIR_RIGHT) ? 0 : 1;
        case (i_dir)
            DIR_RIGHT: w_dc = 1;
            DIR_DOWN:  w_dc = 0;
            DIR_DIAG:  w_dc = 1;
            default:   w_dc = -1;
        endcase
        w_r        = int'(i_row);
        w_c        = int'(i_col);
        w_anchor   = cell_at(i_snap, w_r, w_c);
        // The far end of the run must land on the board; this also rules out row wrap-around.
        w_eligible = (w_r + w_dr*(K-1) < N) && (w_c + w_dc*(K-1) >= 0) && (w_c + w_dc*(K-1) < N);
        w_match    = 1'b1;
        for (int k = 1; k < K; k++)
            if (cell_at(i_snap, w_r + w_dr*k, w_c + w_dc*k) != w_anchor) w_match = 1'b0;
        o_hit    = w_eligible && w_match && is_player(w_anchor);
        o_player = w_anchor;
    end

endmodule

// File: rtl/outcome_scanner.sv
// Sequential NxN K-in-a-row outcome scanner: one anchor cell per clock, row-major, start/done handshake.
// Defining OUTCOME_WIN_LINE_EN adds win_idx/win_dir reporting of the winning anchor and direction.
module outcome_scanner
    import outcome_pkg::*;
#(
    parameter int N = 3,
    parameter int K = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    outcome_scanner_if.slave  scan_if
);

    localparam int CELLS = N*N;
    localparam int IW    = $clog2(CELLS);
    localparam int RW    = $clog2(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(CELLS-1);
    localparam logic [RW-1:0] LAST_COL = RW'(N-1);

    if (N < 3 || N > 8) begin : g_bad_n
        $error("outcome_scanner: N=%0d outside 3..8", N);
    end
    if (K < 3 || K > N) begin : g_bad_k
        $error("outcome_scanner: K=%0d outside 3..N", K);
    end

    state_t           r_state;
    state_t           w_next;
    logic             w_busy;
    logic             w_done;
    logic [2*N*N-1:0] r_snap;
    logic [IW-1:0]    r_idx;
    logic [RW-1:0]    r_row;
    logic [RW-1:0]    r_col;
    logic             r_full;
    logic [1:0]       r_outcome;
    logic [3:0]       w_hit;
    logic [1:0]       w_player [4];
    logic             w_any_hit;
    logic [1:0]       w_hit_player;
    logic [1:0]       w_anchor;
`ifdef OUTCOME_WIN_LINE_EN
    logic [1:0]       w_hit_dir;
    logic [IW-1:0]    r_win_idx;
    logic [1:0]       r_win_dir;
`endif

    for (genvar d = 0; d < 4; d++) begin : g_dir
        outcome_line_check #(.N(N), .K(K), .RW(RW)) u_chk (
            .i_snap   (r_snap),
            .i_row    (r_row),
            .i_col    (r_col),
            .i_dir    (2'(d)),
            .o_hit    (w_hit[d]),
            .o_player (w_player[d])
        );
    end

    // Descending walk so the lowest direction index (highest priority) wins.
    always_comb begin
        w_any_hit    = 1'b0;
        w_hit_player = EMPTY;
`ifdef OUTCOME_WIN_LINE_EN
        w_hit_dir    = DIR_RIGHT;
`endif
        for (int d = 3; d >= 0; d--) begin
            if (w_hit[d]) begin
                w_any_hit    = 1'b1;
                w_hit_player = w_player[d];
`ifdef OUTCOME_WIN_LINE_EN
                w_hit_dir    = 2'(d);
`endif
            end
        end
    end

    always_comb begin
        w_anchor = EMPTY;
        for (int i = 0; i < CELLS; i++)
            if (IW'(i) == r_idx) w_anchor = r_snap[2*i +: 2];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            ST_IDLE: if (scan_if.start) w_next = ST_SCAN;
            ST_SCAN: begin
                w_busy = 1'b1;
                if (w_any_hit || r_idx == LAST_IDX) w_next = ST_DONE;
            end
            ST_DONE: begin
                w_done = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // The snapshot decouples the result from board writes made during a scan.
    always_ff @(posedge clk) begin
        if (r_state == ST_IDLE && scan_if.start) r_snap <= scan_if.board;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx     <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_full    <= 1'b1;
            r_outcome <= IN_PROGRESS;
`ifdef OUTCOME_WIN_LINE_EN
            r_win_idx <= '0;
            r_win_dir <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (scan_if.start) begin
                        r_idx  <= '0;
                        r_row  <= '0;
                        r_col  <= '0;
                        r_full <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    r_full <= r_full & is_player(w_anchor);
                    if (w_any_hit) begin
                        r_outcome <= (w_hit_player == P1) ? P1_WIN : P1_LOSE;
`ifdef OUTCOME_WIN_LINE_EN
                        r_win_idx <= r_idx;
                        r_win_dir <= w_hit_dir;
`endif
                    end else if (r_idx == LAST_IDX) begin
                        // The last cell's occupancy is folded in here, not via r_full.
                        r_outcome <= (r_full && is_player(w_anchor)) ? TIE : IN_PROGRESS;
`ifdef OUTCOME_WIN_LINE_EN
                        r_win_idx <= '0;
                        r_win_dir <= '0;
`endif
                    end else begin
                        r_idx <= r_idx + IW'(1);
                        if (r_col == LAST_COL) begin
                            r_col <= '0;
                            r_row <= r_row + RW'(1);
                        end else begin
                            r_col <= r_col + RW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign scan_if.busy    = w_busy;
    assign scan_if.done    = w_done;
    assign scan_if.outcome = r_outcome;
`ifdef OUTCOME_WIN_LINE_EN
    assign scan_if.win_idx = r_win_idx;
    assign scan_if.win_dir = r_win_dir;
`endif

endmodule
